// File: rtl/vga_capture_pkg.sv
// Shared video timing package: 640x480@60 default timing (800x525 totals),
// capture FSM state encoding and a sync polarity helper.
// Used by the capture block and by video generators driving it.
package vga_capture_pkg;

  // Horizontal timing, in pixel clocks.
  localparam int H_SYNC       = 96;
  localparam int H_BACK       = 48;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT      = 16;
  localparam int H_TOTAL      = H_SYNC + H_BACK + H_ACTIVE_DEF + H_FRONT;  // 800
  localparam int H_START_DEF  = H_SYNC + H_BACK;                           // 144

  // Vertical timing, in lines.
  localparam int V_SYNC       = 2;
  localparam int V_BACK       = 33;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT      = 10;
  localparam int V_TOTAL      = V_SYNC + V_BACK + V_ACTIVE_DEF + V_FRONT;  // 525
  localparam int V_START_DEF  = V_SYNC + V_BACK;                           // 35

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } cap_state_t;

  // Normalise a raw sync pin so that 1 always means "sync asserted".
  function automatic logic sync_asserted(input logic level, input logic active_low);
    return level ^ active_low;
  endfunction

endpackage

// File: rtl/vga_capture_sync.sv
// Sync edge detector plus saturating position counter (one per axis).
// Ports: sync_s1 (normalised sync, s1 stage), step (count enable), gate (when a
// pending edge may reset the count), cnt_clr, cnt (count of the current s1
// sample), cnt_len (previous count + 1), sat_hit (one-cycle saturation event).
module sync_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sync_s1,
  input  logic         step,
  input  logic         gate,
  output logic         cnt_clr,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_len,
  output logic         sat_hit
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic         sync_s2_q, sync_s2_d;
  logic         pend_q, pend_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         sync_edge;

  always_comb begin
    sync_s2_d = sync_s1;
    sync_edge = sync_s1 & ~sync_s2_q;
    // An edge seen while the gate is closed waits for the next gate pulse
    // (vertical: vsync edge waits for the next hsync edge).
    cnt_clr   = gate & (sync_edge | pend_q);
    pend_d    = (pend_q | sync_edge) & ~cnt_clr;
    sat_hit   = 1'b0;
    cnt_d     = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (step && (cnt_q != CNT_MAX)) begin
      cnt_d   = cnt_q + 1'b1;
      sat_hit = (cnt_q == CNT_MAX - 1'b1);
    end
    cnt     = cnt_d;
    cnt_len = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_s2_q <= 1'b0;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_s2_q <= sync_s2_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_capture.sv
// VGA capture: measures incoming sync timing, locks after stable frames and
// emits active pixels with x/y coordinates two cycles after the input sample.
// Ports: clk, reset_n, rgb222/hsync/vsync in; pixel_valid/pixel/x/y,
// new_frame, line_len, frame_lines, locked, sync_err out.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int H_START         = H_START_DEF,
  parameter int H_ACTIVE        = H_ACTIVE_DEF,
  parameter int V_START         = V_START_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF,
  parameter int LOCK_FRAMES     = 2,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  rgb222,
  input  logic        hsync,
  input  logic        vsync,
  output logic        pixel_valid,
  output logic [5:0]  pixel,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        new_frame,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        locked,
  output logic        sync_err
);

  localparam logic        SYNC_LOW  = (SYNC_ACTIVE_LOW != 0);
  localparam logic [10:0] H_START_W = 11'(H_START);
  localparam logic [9:0]  V_START_W = 10'(V_START);

  // Input stage s1.
  logic [5:0] rgb_s1_q, rgb_s1_d;
  logic       hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;

  // Counters.
  logic        h_edge, h_sat, v_clr, v_sat;
  logic [10:0] hcount, h_len;
  logic [9:0]  vcount, v_len;

  // FSM and measurement state.
  cap_state_t  state_q, state_d;
  logic [7:0]  match_q, match_d;
  logic        ref_vld_q, ref_vld_d;
  logic [9:0]  ref_lines_q, ref_lines_d;
  logic        len_vld_q, len_vld_d;
  logic        len_mis_q, len_mis_d;
  logic        line_chk, frame_bad;

  // Outputs.
  logic [10:0] line_len_q, line_len_d;
  logic [9:0]  frame_lines_q, frame_lines_d;
  logic        new_frame_q, new_frame_d;
  logic        sync_err_q, sync_err_d;
  logic        pix_vld_q, pix_vld_d;
  logic [5:0]  pix_q, pix_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        in_h, in_v;

  always_comb begin
    rgb_s1_d = rgb222;
    hs_s1_d  = sync_asserted(hsync, SYNC_LOW);
    vs_s1_d  = sync_asserted(vsync, SYNC_LOW);
  end

  sync_counter #(.W(11)) u_hcnt (
    .clk     (clk),
    .reset_n (reset_n),
    .sync_s1 (hs_s1_q),
    .step    (1'b1),
    .gate    (1'b1),
    .cnt_clr (h_edge),
    .cnt     (hcount),
    .cnt_len (h_len),
    .sat_hit (h_sat)
  );

  // Vertical counter only moves on hsync edges, so a vsync edge takes effect
  // on the same or the next hsync edge.
  sync_counter #(.W(10)) u_vcnt (
    .clk     (clk),
    .reset_n (reset_n),
    .sync_s1 (vs_s1_q),
    .step    (h_edge),
    .gate    (h_edge),
    .cnt_clr (v_clr),
    .cnt     (vcount),
    .cnt_len (v_len),
    .sat_hit (v_sat)
  );

  // Line lengths are compared line to line; the first line after acquisition
  // starts is skipped because its start point is unknown.
  always_comb begin
    line_chk  = h_edge & len_vld_q & (h_len != line_len_q);
    frame_bad = len_mis_q | line_chk | (ref_vld_q & (v_len != ref_lines_q));
  end

  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    ref_vld_d   = ref_vld_q;
    ref_lines_d = ref_lines_q;
    len_vld_d   = len_vld_q;
    len_mis_d   = len_mis_q | line_chk;
    sync_err_d  = 1'b0;
    if (h_edge && (state_q != ST_SEARCH)) begin
      len_vld_d = 1'b1;
    end
    if (h_sat || v_sat) begin
      sync_err_d = 1'b1;
      state_d    = ST_SEARCH;
      match_d    = '0;
      ref_vld_d  = 1'b0;
      len_vld_d  = 1'b0;
      len_mis_d  = 1'b0;
    end else if (v_clr) begin
      len_mis_d   = 1'b0;
      ref_lines_d = v_len;
      ref_vld_d   = 1'b1;
      case (state_q)
        ST_SEARCH: begin
          // Frame since reset/search is partial: do not use it as reference.
          state_d   = ST_TRACK;
          match_d   = '0;
          ref_vld_d = 1'b0;
        end
        default: begin
          if (frame_bad) begin
            sync_err_d = 1'b1;
            match_d    = '0;
            state_d    = ST_TRACK;
          end else if (state_q == ST_TRACK) begin
            // The first complete frame seeds the reference and opens the run.
            match_d = match_q + 8'd1;
            if (int'(match_q) + 1 >= LOCK_FRAMES) begin
              state_d = ST_LOCKED;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    line_len_d    = h_edge ? h_len : line_len_q;
    frame_lines_d = v_clr ? v_len : frame_lines_q;
    new_frame_d   = v_clr;
    in_h = (int'(hcount) >= H_START) && (int'(hcount) < H_START + H_ACTIVE);
    in_v = (int'(vcount) >= V_START) && (int'(vcount) < V_START + V_ACTIVE);
    pix_vld_d = (state_q == ST_LOCKED) && in_h && in_v;
    pix_d     = pix_vld_d ? rgb_s1_q : 6'd0;
    x_d       = pix_vld_d ? 10'(hcount - H_START_W) : 10'd0;
    y_d       = pix_vld_d ? (vcount - V_START_W) : 10'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_s1_q      <= '0;
      hs_s1_q       <= 1'b0;
      vs_s1_q       <= 1'b0;
      state_q       <= ST_SEARCH;
      match_q       <= '0;
      ref_vld_q     <= 1'b0;
      ref_lines_q   <= '0;
      len_vld_q     <= 1'b0;
      len_mis_q     <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      new_frame_q   <= 1'b0;
      sync_err_q    <= 1'b0;
      pix_vld_q     <= 1'b0;
      pix_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
    end else begin
      rgb_s1_q      <= rgb_s1_d;
      hs_s1_q       <= hs_s1_d;
      vs_s1_q       <= vs_s1_d;
      state_q       <= state_d;
      match_q       <= match_d;
      ref_vld_q     <= ref_vld_d;
      ref_lines_q   <= ref_lines_d;
      len_vld_q     <= len_vld_d;
      len_mis_q     <= len_mis_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      new_frame_q   <= new_frame_d;
      sync_err_q    <= sync_err_d;
      pix_vld_q     <= pix_vld_d;
      pix_q         <= pix_d;
      x_q           <= x_d;
      y_q           <= y_d;
    end
  end

  assign pixel_valid = pix_vld_q;
  assign pixel       = pix_q;
  assign x           = x_q;
  assign y           = y_q;
  assign new_frame   = new_frame_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign locked      = (state_q == ST_LOCKED);
  assign sync_err    = sync_err_q;

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameter H_START, default 144, meaning the hcount of the first active pixel (hsync 96 + back porch 48).
REQ-002 SHALL have parameter H_ACTIVE, default 640, meaning the number of active pixels per line.
REQ-003 SHALL have parameter V_START, default 35, meaning the vcount of the first active line (vsync 2 + back porch 33).
REQ-004 SHALL have parameter V_ACTIVE, default 480, meaning the number of active lines per frame.
REQ-005 SHALL have parameter LOCK_FRAMES, default 2, meaning the number of consecutive matching frames required for lock.
REQ-006 SHALL have parameter SYNC_ACTIVE_LOW, default 1, meaning the polarity of hsync/vsync.
REQ-007 SHALL have ports: clk in 1, the single clock; reset_n in 1, the asynchronous active-low reset.
REQ-008 SHALL have ports: rgb222 in 6, hsync in 1, vsync in 1, the incoming video on the clk domain.
REQ-009 SHALL have ports: pixel_valid out 1, pixel out 6, x out 10, y out 10, the captured active pixel.
REQ-010 SHALL have ports: new_frame out 1, line_len out 11, frame_lines out 10, locked out 1, sync_err out 1.

Function
REQ-011 SHALL register rgb222/hsync/vsync once (stage s1) and keep one more sync copy (s2); a sync assertion edge = asserted in s1, deasserted in s2.
REQ-012 SHALL set hcount 0 for the s1 sample carrying an hsync assertion edge, else increment it, saturating at 2047.
REQ-013 SHALL latch line_len = hcount+1 of the previous line's last sample at each hsync edge (11 bits).
REQ-014 SHALL set vcount 0 on the first hsync edge at or after a vsync assertion edge, else increment it at each hsync edge, saturating at 1023.
REQ-015 SHALL latch frame_lines = final vcount+1 at each vsync-driven vcount reset and pulse new_frame for 1 cycle in that cycle.
REQ-016 SHALL assert pixel_valid only when locked=1, H_START<=hcount<H_START+H_ACTIVE and V_START<=vcount<V_START+V_ACTIVE, with x=hcount-H_START, y=vcount-V_START, pixel=s1 rgb222.
REQ-017 SHALL present pixel outputs registered: an input sample at cycle t appears at outputs at t+2; when pixel_valid=0, x, y and pixel SHALL hold 0.
REQ-018 SHALL implement FSM SEARCH -> TRACK on the first vsync edge; TRACK -> LOCKED after LOCK_FRAMES consecutive frames whose line_len and frame_lines both equal the previous frame's.
REQ-019 SHALL, in TRACK or LOCKED, on a line_len or frame_lines mismatch at a frame end, pulse sync_err 1 cycle, clear the match count and enter TRACK.
REQ-020 SHALL, on hcount or vcount saturation in any state, pulse sync_err once and enter SEARCH.
REQ-021 SHALL drive locked=1 exactly while the FSM is in LOCKED; a mismatch drops locked in the same cycle as sync_err.
REQ-022 SHALL, on simultaneous hsync and vsync edges, process the hsync edge first and reset vcount on that same edge.

Reset
REQ-023 SHALL, while reset_n=0, asynchronously clear all state: FSM=SEARCH, counters 0, line_len 0, frame_lines 0, all outputs 0.
REQ-024 SHALL, when reset is asserted mid-frame, restart from SEARCH with no pixel_valid until a new lock is reached.

Structure
REQ-025 SHALL place the FSM state enum and default 640x480 timing constants (800x525 totals) in a shared video timing package also used by the generator.
REQ-026 SHALL isolate the sync edge detector plus counter as sub-module sync_counter, instantiated twice (h and v).

Verification
REQ-027 SHALL verify: standard 800x525 timing from the demo generator -> locked=1 after the 3rd vsync edge; line_len=800, frame_lines=525.
REQ-028 SHALL verify: locked frame -> first pixel_valid with x=0,y=0 two cycles after input hcount=144,vcount=35; last pixel at x=639,y=479; 307200 valid pixels per frame.
REQ-029 SHALL verify: one line shortened to 799 cycles while locked -> sync_err pulse at the frame end, locked=0, relock after 2 clean frames.
REQ-030 SHALL verify: hsync held static for 2100 cycles -> sync_err pulse at saturation and FSM in SEARCH; pixel_valid=0.
REQ-031 SHALL verify: reset_n pulsed low mid-frame while locked -> all outputs 0 immediately; locked returns only after the full lock sequence.
REQ-032 SHALL verify: SYNC_ACTIVE_LOW=0 with inverted syncs -> results identical to REQ-027.
